// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle ARM controller and its shared datapath.
// master = controller side, slave = datapath side.
interface mc_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         AdrSrc;
  logic         MemWrite;
  logic         IRWrite;
  logic         RegWrite;
  logic [1:0]   RegSrc;
  logic [1:0]   ImmSrc;
  logic [1:0]   ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [2:0]   ALUControl;
  logic [3:0]   State;
  logic         InstrDone;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, State, InstrDone
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ALUControl, State, InstrDone
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: FSM with fetch/memory wait states, registered condition check.
// Optional feature: define MC_CTRL_SLT_EN to decode Funct[4:1]=1011 as SLT.
module mc_controller #(
  parameter int FETCH_WAIT = 0,
  parameter int MEM_WAIT   = 0
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.master bus
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] FW = 4'(FETCH_WAIT);
  localparam logic [3:0] MW = 4'(MEM_WAIT);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond;
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];
  assign cond  = bus.Instr[31:28];

  logic unused_rn;
  assign unused_rn = ^bus.Instr[19:16];

  logic [3:0] state, state_nxt, cnt, cnt_lim, flags;
  logic       last, cond_ex_p0, cond_ex_p1;
  logic       adr_src, alu_op, next_pc, ir_write, regw, memw, branch, done;
  logic [1:0] src_a, src_b, res_src, flag_w;
  logic [2:0] alu_ctl;
  logic       no_write, is_arith, is_slt;

  always_comb begin
    case (state)
      S_FETCH:         cnt_lim = FW;
      S_MEMRD, S_MEMWR: cnt_lim = MW;
      default:         cnt_lim = 4'd0;
    endcase
  end
  assign last = (cnt == cnt_lim);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (last) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_nxt = S_MEMADR;
          2'b00:   state_nxt = funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (last) state_nxt = S_MEMWB;
      S_MEMWR:  if (last) state_nxt = S_FETCH;
      S_EXECR, S_EXECI: state_nxt = S_ALUWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Condition evaluation against the architectural flags {N,Z,C,V}
  always_comb begin
    case (cond)
      4'b0000: cond_ex_p0 = flags[2];
      4'b0001: cond_ex_p0 = ~flags[2];
      4'b0010: cond_ex_p0 = flags[1];
      4'b0011: cond_ex_p0 = ~flags[1];
      4'b0100: cond_ex_p0 = flags[3];
      4'b0101: cond_ex_p0 = ~flags[3];
      4'b0110: cond_ex_p0 = flags[0];
      4'b0111: cond_ex_p0 = ~flags[0];
      4'b1000: cond_ex_p0 = flags[1] & ~flags[2];
      4'b1001: cond_ex_p0 = ~flags[1] | flags[2];
      4'b1010: cond_ex_p0 = (flags[3] == flags[0]);
      4'b1011: cond_ex_p0 = (flags[3] != flags[0]);
      4'b1100: cond_ex_p0 = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex_p0 = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex_p0 = 1'b1;
      default: cond_ex_p0 = 1'b0;
    endcase
  end

  // Data-processing decode; NoWrite must stay valid through ALUWB, so it is not gated by ALUOp
  always_comb begin
    alu_ctl  = 3'b000;
    no_write = 1'b0;
    is_arith = 1'b0;
    is_slt   = 1'b0;
    if (op == 2'b00) begin
      case (funct[4:1])
        4'b0100: is_arith = 1'b1;
        4'b0010: begin alu_ctl = 3'b001; is_arith = 1'b1; end
        4'b0000: alu_ctl = 3'b010;
        4'b1100: alu_ctl = 3'b011;
        4'b1010: begin alu_ctl = 3'b001; is_arith = 1'b1; no_write = 1'b1; end
        4'b1011: begin
          is_slt = 1'b1;
`ifdef MC_CTRL_SLT_EN
          alu_ctl = 3'b100;
`else
          no_write = 1'b1;
`endif
        end
        default: no_write = 1'b1;
      endcase
    end
  end
  assign flag_w[1] = alu_op & funct[0] & ~is_slt;
  assign flag_w[0] = alu_op & funct[0] & is_arith;

  always_comb begin
    adr_src  = 1'b0;
    src_a    = 2'b00;
    src_b    = 2'b00;
    res_src  = 2'b00;
    alu_op   = 1'b0;
    next_pc  = 1'b0;
    ir_write = 1'b0;
    regw     = 1'b0;
    memw     = 1'b0;
    branch   = 1'b0;
    done     = 1'b0;
    case (state)
      S_FETCH:  begin src_a = 2'b01; src_b = 2'b10; res_src = 2'b10;
                      ir_write = last; next_pc = last; end
      S_DECODE: begin src_a = 2'b01; src_b = 2'b10; res_src = 2'b10;
                      done = (op == 2'b11); end
      S_MEMADR: src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB:  begin res_src = 2'b01; regw = 1'b1; done = 1'b1; end
      S_MEMWR:  begin adr_src = 1'b1; memw = last; done = last; end
      S_EXECR:  alu_op = 1'b1;
      S_EXECI:  begin src_b = 2'b01; alu_op = 1'b1; end
      S_ALUWB:  begin regw = 1'b1; done = 1'b1; end
      S_BRANCH: begin src_a = 2'b10; src_b = 2'b01; res_src = 2'b10;
                      branch = 1'b1; done = 1'b1; end
      default:  ;
    endcase
  end

  // State, wait counter, flags and registered condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      cnt        <= 4'd0;
      flags      <= 4'd0;
      cond_ex_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      cond_ex_p1 <= cond_ex_p0;
      if (state_nxt != state) cnt <= 4'd0;
      else if (!last)         cnt <= cnt + 4'd1;
      if (cond_ex_p0) begin
        if (flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  logic rd_pc;
  assign rd_pc = (rd == 4'hF);

  assign bus.PCWrite    = ~reset & (next_pc |
                          ((branch | (regw & rd_pc & ~no_write)) & cond_ex_p1));
  assign bus.RegWrite   = ~reset & regw & cond_ex_p1 & ~no_write & ~rd_pc;
  assign bus.MemWrite   = ~reset & memw & cond_ex_p1;
  assign bus.IRWrite    = ~reset & ir_write;
  assign bus.InstrDone  = ~reset & done;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.ImmSrc     = op;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUControl = alu_op ? alu_ctl : 3'b000;
  assign bus.State      = state;
endmodule
